// File: rtl/rr_arbiter_4_pkg.sv
// Shared constants and state encoding for the 4-requester round-robin arbiter.
package arb_pkg;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_4_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (output req, input gnt, input gnt_idx, input gnt_valid, input timeout);
    modport slave  (input req, output gnt, output gnt_idx, output gnt_valid, output timeout);
endinterface

// File: rtl/rr_arbiter_4_pick4.sv
// Rotating-priority 4-to-2 encoder: the first set request at or after ptr wins.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    always_comb begin
        rot = '0;
        off = '0;
        // Bit i of rot is request (ptr + i) mod 4; truncation to IDX_W does the wrap.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rot[i] = req[IDX_W'(i + 32'(ptr))];
        end
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (rot[i-1]) off = IDX_W'(i - 1);
        end
        any = |req;
        idx = off + ptr;
    end
endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters with registered one-hot grant
// and a per-tenure hold limit.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter_4_if.slave  bus
);
    localparam int unsigned     HC_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0]  hc_q, hc_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             to_q, to_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hc_q    <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hc_q    <= hc_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hc_d    = hc_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                if (pick_any) begin
                    gnt_d   = N_REQ'(1) << pick_idx;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    hc_d    = HC_W'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Either way the tenure ends, the owner drops to lowest priority.
                if (!bus.req[idx_q] || ((MAX_HOLD != 0) && (hc_q == HC_MAX))) begin
                    to_d    = bus.req[idx_q];
                    gnt_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + IDX_W'(1);
                    state_d = IDLE;
                end else if (hc_q != '1) begin
                    hc_d = hc_q + HC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = to_q;
endmodule
